// File: rtl/cordic_prerotate.sv
// Input conditioning ahead of CORDIC stage 0: +/-pi pre-rotation into the circular convergence range,
// registered valid/ready stage with a 1-entry skid buffer. Define CORDIC_PRE_SAT_EN to saturate -2^(M-1) negation.
module cordic_prerotate #(
   parameter int M     = 32,
   parameter int PI_Q  = 1686629713,
   parameter int HPI_Q = 843314857
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] x_in,
   input  logic [M-1:0] y_in,
   input  logic [M-1:0] z_in,
   input  logic [1:0]   mode_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] x_out,
   output logic [M-1:0] y_out,
   output logic [M-1:0] z_out,
   output logic [1:0]   mode_out,
   output logic         flip_out
);

   localparam logic [M-1:0] PI_V   = M'(PI_Q);
   localparam logic [M-1:0] HPI_V  = M'(HPI_Q);
   localparam logic [M-1:0] NHPI_V = M'(-HPI_Q);

   typedef struct packed {
      logic [1:0]   mode;
      logic         flip;
      logic [M-1:0] x;
      logic [M-1:0] y;
      logic [M-1:0] z;
   } item_t;

   typedef enum logic [1:0] {
      EMPTY,
      FULL,
      SKID
   } state_t;

   state_t state, state_n;
   item_t  out_q, skid_q, cond;
   logic   in_ready_n;
   logic   accept, drain;
   logic   load_out, load_skid, out_from_skid;

   function automatic logic [M-1:0] neg(input logic [M-1:0] v);
      logic [M-1:0] r;
`ifdef CORDIC_PRE_SAT_EN
      if (v == {1'b1, {(M-1){1'b0}}})
         r = {1'b0, {(M-1){1'b1}}};
      else
         r = -v;
`else
      r = -v;
`endif
      return r;
   endfunction

   always_comb begin
      cond.mode = mode_in;
      cond.flip = 1'b0;
      cond.x    = x_in;
      cond.y    = y_in;
      cond.z    = z_in;
      unique case (mode_in)
         2'b00: begin
            if ($signed(z_in) > $signed(HPI_V)) begin
               cond.x    = neg(x_in);
               cond.y    = neg(y_in);
               cond.z    = z_in - PI_V;
               cond.flip = 1'b1;
            end else if ($signed(z_in) < $signed(NHPI_V)) begin
               cond.x    = neg(x_in);
               cond.y    = neg(y_in);
               cond.z    = z_in + PI_V;
               cond.flip = 1'b1;
            end
         end
         2'b01: begin
            // left half-plane: rotate by pi, angle sign chosen from the original y
            if (x_in[M-1]) begin
               cond.x    = neg(x_in);
               cond.y    = neg(y_in);
               cond.z    = y_in[M-1] ? (z_in - PI_V) : (z_in + PI_V);
               cond.flip = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_n       = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               load_out = 1'b1;
               state_n  = FULL;
            end
         end
         FULL: begin
            if (drain) begin
               if (accept)
                  load_out = 1'b1;
               else
                  state_n = EMPTY;
            end else if (accept) begin
               load_skid = 1'b1;
               state_n   = SKID;
            end
         end
         SKID: begin
            if (drain) begin
               out_from_skid = 1'b1;
               state_n       = FULL;
            end
         end
         default: state_n = EMPTY;
      endcase
      in_ready_n = (state_n != SKID);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= state_n;
         in_ready <= in_ready_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)
            out_q <= cond;
         else if (out_from_skid)
            out_q <= skid_q;
         if (load_skid)
            skid_q <= cond;
      end
   end

   assign x_out    = out_q.x;
   assign y_out    = out_q.y;
   assign z_out    = out_q.z;
   assign mode_out = out_q.mode;
   assign flip_out = out_q.flip;

endmodule
